cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 127 ++++++++++++
 tb/tb_cpu_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer for a small CPU.
//   Walks FETCH -> DECODE -> EXEC -> (MULW x2) -> WB, owns pc, ir and the
//   status flags, and emits one-cycle reg_we / retire strobes in WB.
// Ports:
//   clk, rst          clock, async active-high reset
//   run               fetch enable (sampled only in FETCH)
//   imem_req/addr     instruction fetch request / address (= pc)
//   imem_ready/rdata  fetch handshake and instruction word
//   ir                latched instruction to the control unit
//   load_pc/_val      branch taken / target from the control unit
//   reg_write_enable  control unit says the instruction writes a register
//   alu_zero/alu_neg  ALU flags, captured by CMP in WB
//   status_reg        {6'b0, NEG, EQ}
//   pc                program counter
//   reg_we, retire    one-cycle strobes in WB
//   halted, state     HALT indicator and debug state code
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  input  logic        load_pc,
  input  logic [11:0] load_pc_val,
  input  logic        reg_write_enable,
  input  logic        alu_zero,
  input  logic        alu_neg,
  output logic [7:0]  status_reg,
  output logic [11:0] pc,
  output logic        reg_we,
  output logic        retire,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MULW   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  stat_q, stat_d;   // {NEG, EQ}
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  opcode;

  assign opcode     = ir_q[15:12];
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign status_reg = {6'b0, stat_q};
  assign state      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 12'h000;
      ir_q    <= 16'h0000;
      stat_q  <= 2'b00;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    stat_d   = stat_q;
    cnt_d    = cnt_q;
    imem_req = 1'b0;
    reg_we   = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = run;
        if (run && imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      // One idle cycle so control-unit outputs derived from ir settle.
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (opcode == OP_MUL) begin
          cnt_d   = 2'd2;
          state_d = S_MULW;
        end else begin
          state_d = S_WB;
        end
      end
      S_MULW: begin
        cnt_d = cnt_q - 2'd1;
        // Leave once the count reaches zero; <= also guards a stray 0.
        if (cnt_q <= 2'd1) state_d = S_WB;
      end
      S_WB: begin
        reg_we = reg_write_enable;
        retire = 1'b1;
        pc_d   = load_pc ? load_pc_val : pc_q + 12'd1;
        if (opcode == OP_CMP) stat_d = {alu_neg, alu_zero};
        state_d = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: table of instructions with expected results,
// a scoreboard queue, and hand sequences for run drop, reset in MULW and HALT.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, imem_ready, alu_zero, alu_neg;
  logic [15:0] imem_rdata;
  logic        imem_req, reg_we, retire, halted;
  logic [11:0] imem_addr, pc, load_pc_val;
  logic [15:0] ir;
  logic [7:0]  status_reg;
  logic [2:0]  state;
  logic        load_pc, reg_write_enable;

  // Minimal control unit: JEQ (4'hB) branches on EQ, ADD/MUL write a register.
  assign load_pc          = (ir[15:12] == 4'hB) && status_reg[0];
  assign load_pc_val      = ir[11:0];
  assign reg_write_enable = (ir[15:12] == 4'h1) || (ir[15:12] == 4'h3);

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .load_pc(load_pc), .load_pc_val(load_pc_val),
    .reg_write_enable(reg_write_enable),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .status_reg(status_reg), .pc(pc),
    .reg_we(reg_we), .retire(retire), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [15:0] w;
    logic        z;
    logic        n;
    int          rdly;   // cycles imem_ready held low in FETCH
    logic [11:0] pc;     // pc after WB
    logic [1:0]  st;     // {NEG,EQ} after WB
    int          lat;    // fetch-to-retire cycles
    logic        we;
    logic        hlt;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge
  // after WB. Expected state per cycle is modelled from latency rules.
  task automatic run_vec(input vec_t v, input string nm);
    vec_t e;
    int lat, bad, k;
    logic we;
    logic [2:0] es;
    bit mul;
    lat = 0; bad = 0; we = 1'b0;
    mul = (v.w[15:12] == 4'h3);
    sb.push_back(v);
    imem_rdata = v.w; alu_zero = v.z; alu_neg = v.n;
    for (int c = 1; c <= 40; c++) begin
      imem_ready = (c > v.rdly);
      k = c - v.rdly;
      if (k <= 1)              es = 3'd0;
      else if (k == 2)         es = 3'd1;
      else if (k == 3)         es = 3'd2;
      else if (mul && k <= 5)  es = 3'd3;
      else                     es = 3'd4;
      if (state !== es || imem_req !== ((es == 3'd0) ? run : 1'b0)) bad++;
      if (retire) begin lat = c; we = reg_we; break; end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    e = sb.pop_front();
    chk({nm, " latency"}, 32'(lat), 32'(e.lat));
    chk({nm, " reg_we"}, {31'b0, we}, {31'b0, e.we});
    chk({nm, " trace"}, 32'(bad), 32'd0);
    @(negedge clk);
    chk({nm, " pc"}, {20'b0, pc}, {20'b0, e.pc});
    chk({nm, " status"}, {24'b0, status_reg}, {30'b0, e.st});
    chk({nm, " halted"}, {31'b0, halted}, {31'b0, e.hlt});
  endtask

  initial begin
    int bad;
    bit got, weseen;
    vecs[0]  = '{16'h1123, 1'b0, 1'b0, 0, 12'h001, 2'b00, 4, 1'b1, 1'b0};
    vecs[1]  = '{16'h3123, 1'b0, 1'b0, 0, 12'h002, 2'b00, 6, 1'b1, 1'b0};
    vecs[2]  = '{16'hA000, 1'b1, 1'b0, 0, 12'h003, 2'b01, 4, 1'b0, 1'b0};
    vecs[3]  = '{16'hB0F0, 1'b0, 1'b0, 0, 12'h0F0, 2'b01, 4, 1'b0, 1'b0};
    vecs[4]  = '{16'hA000, 1'b0, 1'b1, 0, 12'h0F1, 2'b10, 4, 1'b0, 1'b0};
    vecs[5]  = '{16'hB0F0, 1'b0, 1'b0, 0, 12'h0F2, 2'b10, 4, 1'b0, 1'b0};
    vecs[6]  = '{16'h1123, 1'b0, 1'b0, 5, 12'h0F3, 2'b10, 9, 1'b1, 1'b0};
    vecs[7]  = '{16'h3456, 1'b0, 1'b0, 2, 12'h0F4, 2'b10, 8, 1'b1, 1'b0};
    vecs[8]  = '{16'hA000, 1'b1, 1'b1, 0, 12'h0F5, 2'b11, 4, 1'b0, 1'b0};
    vecs[9]  = '{16'hBFFF, 1'b0, 1'b0, 0, 12'hFFF, 2'b11, 4, 1'b0, 1'b0};
    vecs[10] = '{16'h1000, 1'b0, 1'b1, 0, 12'h000, 2'b11, 4, 1'b1, 1'b0};
    vecs[11] = '{16'h0000, 1'b1, 1'b0, 0, 12'h001, 2'b11, 4, 1'b0, 1'b0};

    rst = 1'b1; run = 1'b1; imem_ready = 1'b0; imem_rdata = 16'h0;
    alu_zero = 1'b0; alu_neg = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst state", {29'b0, state}, 32'd0);
    chk("rst pc", {20'b0, pc}, 32'd0);
    chk("rst ir", {16'b0, ir}, 32'd0);
    chk("rst flags", {24'b0, status_reg}, 32'd0);
    chk("rst strobes", {29'b0, reg_we, retire, halted}, 32'd0);
    chk("rst imem_req", {31'b0, imem_req}, 32'd1);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // run dropped after fetch: instruction still completes, no further fetch.
    imem_rdata = 16'h1123; imem_ready = 1'b1; run = 1'b1;
    @(negedge clk);
    run = 1'b0; imem_ready = 1'b0; got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (retire) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("rundrop retire", {31'b0, got}, 32'd1);
    imem_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rundrop pc", {20'b0, pc}, 32'h002);
    chk("rundrop idle", {28'b0, imem_req, state}, 32'd0);

    // reset asserted while in MULW
    run = 1'b1; imem_rdata = 16'h3123; imem_ready = 1'b1;
    got = 1'b0; weseen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (reg_we) weseen = 1'b1;
      if (state == 3'd3) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("mulrst reached MULW", {31'b0, got}, 32'd1);
    rst = 1'b1; imem_ready = 1'b0;
    #1;
    if (reg_we) weseen = 1'b1;
    chk("mulrst state", {29'b0, state}, 32'd0);
    chk("mulrst pc", {20'b0, pc}, 32'd0);
    chk("mulrst ir", {16'b0, ir}, 32'd0);
    chk("mulrst flags", {24'b0, status_reg}, 32'd0);
    chk("mulrst no reg_we", {31'b0, weseen}, 32'd0);
    chk("mulrst imem_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_vec('{16'hF000, 1'b0, 1'b0, 0, 12'h001, 2'b00, 4, 1'b0, 1'b1}, "halt");

    // HALT is absorbing even with a ready instruction memory.
    imem_ready = 1'b1; imem_rdata = 16'h1123; bad = 0;
    repeat (5) begin
      if (!halted || imem_req || retire || reg_we || pc !== 12'h001 || state !== 3'd5) bad++;
      @(negedge clk);
    end
    chk("halt absorbing", 32'(bad), 32'd0);
    rst = 1'b1;
    #1;
    chk("halt rst state", {29'b0, state}, 32'd0);
    chk("halt rst halted", {31'b0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
